// File: rtl/sdram_frame_reader_pkg.sv
// Shared definitions for the SDRAM frame reader.
//   state_t           : reader FSM state encoding (also visible on dbg_state)
//   cnt_width()       : bits needed to hold 0..max_val
//   BYTES_PER_WORD,
//   BURSTS_PER_FRAME,
//   *_CNT_W           : constants for the default configuration; the reader
//                       recomputes the same quantities from its own parameters
//                       with the same helper so every instance is self-consistent.
package sdram_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_WIDTH_DATA = 64;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_LINE_WORDS = 64;
  localparam int DEF_LINES      = 480;
  localparam int DEF_FIFO_DEPTH = 64;

  localparam int BYTES_PER_WORD   = DEF_WIDTH_DATA / 8;
  localparam int BURSTS_PER_FRAME = DEF_LINE_WORDS * DEF_LINES / DEF_BURST_LEN;
  localparam int BURST_CNT_W      = $clog2(BURSTS_PER_FRAME + 1);
  localparam int WORD_CNT_W       = $clog2(DEF_LINE_WORDS);
  localparam int LINE_CNT_W       = $clog2(DEF_LINES);
  localparam int OUTST_CNT_W      = $clog2(DEF_FIFO_DEPTH + 1);

endpackage

// File: rtl/sdram_frame_reader_fifo.sv
// sync_fifo_fwft: show-ahead synchronous FIFO.
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   wr_en, wr_data  : write port; a write to a full FIFO is taken only when a
//                     read happens in the same cycle (occupancy then unchanged)
//   rd_en, rd_data  : rd_data always shows the head word; rd_en pops it
//   empty, usedw    : status; usedw ranges 0..DEPTH
// A word written at edge N is on rd_data right after edge N (1-cycle latency).
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     usedw
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (usedw == '0);
  assign full    = (usedw == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      usedw <= usedw + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  end
endmodule

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: reads one LINES x LINE_WORDS frame from SDRAM with
// fixed-length read bursts and replays it as a framed stream.
//   clk, reset            : sole clock, synchronous active-high reset
//   start, base_addr      : one-cycle launch (IDLE only) and frame byte address
//   busy, done            : busy outside IDLE; done pulses for one cycle at end
//   address, burstcount,
//   read, waitrequest,
//   readdata, readdatavalid : pipelined burst read master
//   st_data, st_valid,
//   st_ready, st_sop, st_eop,
//   st_sof, st_eof        : output stream with line/frame sideband
//   dbg_state             : current FSM state (sdram_frame_pkg::state_t)
//   stall_cnt             : only with SDRAM_FRAME_READER_STAT_EN defined
// Handshakes: a stream word moves on any edge where st_valid && st_ready;
// st_valid never waits on st_ready, and data/flags hold until that edge.
// A burst request moves on any edge where read && !waitrequest; address,
// burstcount and read hold while waitrequest is high.
module sdram_frame_reader
  import sdram_frame_pkg::*;
#(
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 64,
  parameter int BURST_LEN  = 16,
  parameter int LINE_WORDS = 64,
  parameter int LINES      = 480,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH_ADDR-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH_ADDR-1:0] address,
  output logic [7:0]            burstcount,
  output logic                  read,
  input  logic                  waitrequest,
  input  logic [WIDTH_DATA-1:0] readdata,
  input  logic                  readdatavalid,
  output logic [WIDTH_DATA-1:0] st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_sop,
  output logic                  st_eop,
  output logic                  st_sof,
  output logic                  st_eof,
  output logic [1:0]            dbg_state
`ifdef SDRAM_FRAME_READER_STAT_EN
  ,output logic [31:0]          stall_cnt
`endif
);
  localparam int BPW    = WIDTH_DATA / 8;
  localparam int BURSTS = LINE_WORDS * LINES / BURST_LEN;
  localparam int BCW    = cnt_width(BURSTS);
  localparam int WCW    = cnt_width(LINE_WORDS - 1);
  localparam int LCW    = cnt_width(LINES - 1);
  localparam int OCW    = cnt_width(FIFO_DEPTH);
  localparam int UW     = $clog2(FIFO_DEPTH) + 1;
  localparam int SW     = OCW + 2;
  localparam int DCW    = cnt_width(2 * BURST_LEN);

  state_t          state;
  logic [BCW-1:0]  bursts;
  logic [OCW-1:0]  outstanding;
  logic [WCW-1:0]  word_cnt;
  logic [LCW-1:0]  line_cnt;
  logic [DCW-1:0]  discard_cnt;
  logic [UW-1:0]   usedw;
  logic            fifo_empty;
  logic            issue, wr_en, dec, credit_ok, xfer;
  logic            at_sol, at_eol, first_line, last_line;

  assign issue = read && !waitrequest;
  // Returning words are dropped while the post-reset discard window runs.
  assign wr_en = readdatavalid && (discard_cnt == '0);
  assign dec   = wr_en && (outstanding != '0);
  // Request only if the FIFO can absorb everything already in flight plus
  // one more burst; this is what keeps the FIFO from ever overflowing.
  assign credit_ok = (SW'(usedw) + SW'(outstanding) + SW'(BURST_LEN)) <= SW'(FIFO_DEPTH);
  assign xfer = st_valid && st_ready;

  sync_fifo_fwft #(.WIDTH(WIDTH_DATA), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (readdata),
    .rd_en   (xfer),
    .rd_data (st_data),
    .empty   (fifo_empty),
    .usedw   (usedw)
  );

  assign st_valid   = !fifo_empty;
  assign at_sol     = (word_cnt == '0);
  assign at_eol     = (word_cnt == WCW'(LINE_WORDS - 1));
  assign first_line = (line_cnt == '0);
  assign last_line  = (line_cnt == LCW'(LINES - 1));
  // Flags derive from transfer counters, so they only move after a transfer.
  assign st_sop = st_valid && at_sol;
  assign st_eop = st_valid && at_eol;
  assign st_sof = st_valid && at_sol && first_line;
  assign st_eof = st_valid && at_eol && last_line;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      read        <= 1'b0;
      address     <= '0;
      burstcount  <= '0;
      done        <= 1'b0;
      bursts      <= '0;
      outstanding <= '0;
      word_cnt    <= '0;
      line_cnt    <= '0;
      // A reset that interrupts a frame (or is held) opens a window in which
      // late read data from the aborted bursts is thrown away.
      if (state != ST_IDLE || discard_cnt != '0) discard_cnt <= DCW'(2 * BURST_LEN);
      else discard_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
      outstanding <= outstanding + (issue ? OCW'(BURST_LEN) : '0) - (dec ? OCW'(1) : '0);

      if (xfer) begin
        if (at_eol) begin
          word_cnt <= '0;
          line_cnt <= last_line ? '0 : line_cnt + 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_REQ;
            address     <= base_addr;
            bursts      <= '0;
            outstanding <= '0;
            word_cnt    <= '0;
            line_cnt    <= '0;
          end
        end
        ST_REQ: begin
          if (read) begin
            if (!waitrequest) begin
              // One idle cycle after each issue lets the credit check see
              // the updated outstanding count before the next request.
              read       <= 1'b0;
              burstcount <= '0;
              address    <= address + WIDTH_ADDR'(BPW * BURST_LEN);
              bursts     <= bursts + 1'b1;
              if (bursts == BCW'(BURSTS - 1)) state <= ST_DRAIN;
            end
          end else if (credit_ok) begin
            read       <= 1'b1;
            burstcount <= 8'(BURST_LEN);
          end
        end
        ST_DRAIN: ;
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (xfer && st_eof && state != ST_IDLE) begin
        state      <= ST_FIN;
        done       <= 1'b1;
        read       <= 1'b0;
        burstcount <= '0;
      end
    end
  end

`ifdef SDRAM_FRAME_READER_STAT_EN
  // Cycles where the consumer is ready but the buffer has nothing to give.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (state == ST_IDLE && start) stall_cnt <= '0;
    else if (busy && st_ready && fifo_empty && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sdram_frame_reader.sv
module tb_sdram_frame_reader;
  localparam int AW = 32, DW = 64, BL = 8, LW = 16, LN = 2, FD = 32;
  localparam int WORDS = LW * LN, BURSTS = WORDS / BL, BYTES = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, waitrequest, readdatavalid, st_ready;
  logic [AW-1:0] base_addr, address;
  logic [DW-1:0] readdata, st_data;
  logic [7:0]    burstcount;
  logic [1:0]    dbg_state;
  logic          busy, done, read, st_valid, st_sop, st_eop, st_sof, st_eof;
`ifdef SDRAM_FRAME_READER_STAT_EN
  logic [31:0]   stall_cnt;
`endif

  sdram_frame_reader #(
    .WIDTH_ADDR(AW), .WIDTH_DATA(DW), .BURST_LEN(BL),
    .LINE_WORDS(LW), .LINES(LN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .address(address), .burstcount(burstcount),
    .read(read), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop), .st_sof(st_sof),
    .st_eof(st_eof), .dbg_state(dbg_state)
`ifdef SDRAM_FRAME_READER_STAT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] slave_q[$];

  // Memory contents as seen by the slave model: a pure function of address.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            wait_burst;
    int            wait_cycles;
    int            stall_word;
    int            stall_cycles;
    int            rdv_delay;
    bit            random_mode;
    int            ignore_at;
    logic [AW-1:0] ignore_base;
    int            exp_bursts;
    int            exp_words;
    int            exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check_reset_values(input string tag);
    check({tag, "_read"},       64'(read),       64'(0));
    check({tag, "_address"},    64'(address),    64'(0));
    check({tag, "_burstcount"}, 64'(burstcount), 64'(0));
    check({tag, "_busy"},       64'(busy),       64'(0));
    check({tag, "_done"},       64'(done),       64'(0));
    check({tag, "_st_valid"},   64'(st_valid),   64'(0));
    check({tag, "_flags"},      64'({st_sop, st_eop, st_sof, st_eof}), 64'(0));
    check({tag, "_state"},      64'(dbg_state),  64'(0));
  endtask

  // ---------------- driver + reference model for one frame ----------------
  // Drives one frame at the negative edge; the reference expectations come
  // from the frame geometry alone: word k lives at base + k*BYTES, burst b
  // at base + b*BL*BYTES, and the flags follow from k's line position.
  task automatic run_frame(input vec_t v, input int reset_at, output int cycles_to_done);
    int bursts_seen, words_rx, done_seen, wait_left, stall_left, delay_left;
    int cyc, max_occ, occ, k;
    bit stall_started, ignored, finished;
    logic [DW-1:0] exp_word;
    logic [3:0]    exp_flags;

    exp_q.delete();
    slave_q.delete();
    for (int i = 0; i < WORDS; i++) exp_q.push_back(word_of(v.base + AW'(i * BYTES)));
    bursts_seen = 0; words_rx = 0; done_seen = 0; max_occ = 0;
    wait_left = v.wait_cycles; stall_left = 0; delay_left = v.rdv_delay;
    stall_started = 0; ignored = 0; finished = 0; cycles_to_done = 0;

    @(negedge clk);
    base_addr = v.base;
    start     = 1'b1;
    cyc       = 0;
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;

      if (reset_at >= 0 && words_rx == reset_at) begin
        reset = 1'b1; readdatavalid = 1'b0; waitrequest = 1'b0; st_ready = 1'b0;
        return;
      end
      if (cyc == 1) check("busy_after_start", 64'(busy), 64'(1));
      if (v.ignore_at >= 0 && !ignored && words_rx >= v.ignore_at) begin
        start = 1'b1; base_addr = v.ignore_base; ignored = 1;
      end

      if (done) begin
        done_seen++;
        if (cycles_to_done == 0) cycles_to_done = cyc;
        check("done_after_last_word", 64'(words_rx), 64'(WORDS));
      end else if (done_seen > 0) begin
        finished = 1;
        check("busy_after_done", 64'(busy), 64'(0));
      end

      // Slave return path: data only after its burst was accepted.
      readdatavalid = 1'b0;
      readdata      = '0;
      if (bursts_seen > 0 && delay_left > 0) delay_left--;
      else if (slave_q.size() > 0 && (!v.random_mode || $urandom_range(0, 2) != 0)) begin
        readdatavalid = 1'b1;
        readdata      = slave_q.pop_front();
      end

      // Slave command path.
      waitrequest = 1'b0;
      if (read) begin
        if (bursts_seen == v.wait_burst && wait_left > 0) begin
          waitrequest = 1'b1; wait_left--;
        end else if (v.random_mode && $urandom_range(0, 3) == 0) waitrequest = 1'b1;
        check("burst_address", 64'(address), 64'(v.base + AW'(bursts_seen * BL * BYTES)));
        check("burstcount", 64'(burstcount), 64'(BL));
        if (!waitrequest) begin
          for (int i = 0; i < BL; i++)
            slave_q.push_back(word_of(v.base + AW'((bursts_seen * BL + i) * BYTES)));
          bursts_seen++;
        end
      end

      // Stream sink.
      if (v.stall_word >= 0 && !stall_started && words_rx == v.stall_word) begin
        stall_started = 1; stall_left = v.stall_cycles;
      end
      if (stall_left > 0) begin
        st_ready = 1'b0; stall_left--;
      end else st_ready = !v.random_mode || ($urandom_range(0, 3) != 0);

      if (st_valid && st_ready) begin
        k = words_rx;
        exp_word  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        exp_flags = {(k % LW) == 0, (k % LW) == LW - 1, k == 0, k == WORDS - 1};
        check("stream_data", st_data, exp_word);
        check("stream_flags", 64'({st_sop, st_eop, st_sof, st_eof}), 64'(exp_flags));
        words_rx++;
      end

      occ = bursts_seen * BL - words_rx;
      if (occ > max_occ) max_occ = occ;
    end

    check("frame_completed", 64'(finished), 64'(1));
    check("burst_count_total", 64'(bursts_seen), 64'(v.exp_bursts));
    check("word_count_total", 64'(words_rx), 64'(v.exp_words));
    check("done_pulses", 64'(done_seen), 64'(v.exp_done));
    check("in_flight_bound", 64'(max_occ <= FD), 64'(1));
    check("min_frame_cycles", 64'(cycles_to_done >= WORDS), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc_done;
    vec_t vr, vc;

    vecs[0] = '{base:32'h0000_1000, wait_burst:-1, wait_cycles:0, stall_word:-1, stall_cycles:0,
                rdv_delay:0, random_mode:1'b0, ignore_at:-1, ignore_base:32'h0,
                exp_bursts:BURSTS, exp_words:WORDS, exp_done:1};
    vecs[1] = '{base:32'h0000_2000, wait_burst:2, wait_cycles:5, stall_word:-1, stall_cycles:0,
                rdv_delay:0, random_mode:1'b0, ignore_at:-1, ignore_base:32'h0,
                exp_bursts:BURSTS, exp_words:WORDS, exp_done:1};
    vecs[2] = '{base:32'h0000_0000, wait_burst:-1, wait_cycles:0, stall_word:12, stall_cycles:200,
                rdv_delay:0, random_mode:1'b0, ignore_at:-1, ignore_base:32'h0,
                exp_bursts:BURSTS, exp_words:WORDS, exp_done:1};
    vecs[3] = '{base:AW'($urandom) & ~32'h7, wait_burst:-1, wait_cycles:0, stall_word:-1, stall_cycles:0,
                rdv_delay:0, random_mode:1'b1, ignore_at:-1, ignore_base:32'h0,
                exp_bursts:BURSTS, exp_words:WORDS, exp_done:1};
    vecs[4] = '{base:32'h0000_4000, wait_burst:-1, wait_cycles:0, stall_word:-1, stall_cycles:0,
                rdv_delay:20, random_mode:1'b0, ignore_at:-1, ignore_base:32'h0,
                exp_bursts:BURSTS, exp_words:WORDS, exp_done:1};
    vecs[5] = '{base:32'h0000_5000, wait_burst:-1, wait_cycles:0, stall_word:-1, stall_cycles:0,
                rdv_delay:0, random_mode:1'b0, ignore_at:5, ignore_base:32'hDEAD_0000,
                exp_bursts:BURSTS, exp_words:WORDS, exp_done:1};

    reset = 1'b1; start = 1'b0; base_addr = '0; waitrequest = 1'b0;
    readdatavalid = 1'b0; readdata = '0; st_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("por");
`ifdef SDRAM_FRAME_READER_STAT_EN
    check("por_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      run_frame(vecs[t], -1, cyc_done);
`ifdef SDRAM_FRAME_READER_STAT_EN
      if (vecs[t].rdv_delay > 0) begin
        // With st_ready held high every busy cycle either moves one word or stalls.
        check("stall_cnt_total", 64'(stall_cnt), 64'(cyc_done - WORDS));
        check("stall_cnt_min", 64'(stall_cnt >= 32'(vecs[t].rdv_delay)), 64'(1));
      end
`endif
      repeat (2) @(negedge clk);
    end

    // Reset at word 10, stale returns inside the discard window, then a clean frame.
    vr = vecs[0];
    vr.base = 32'h0000_3000;
    run_frame(vr, 10, cyc_done);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    for (int i = 0; i < 5; i++) begin
      readdatavalid = 1'b1;
      readdata = 64'hBAD0_BAD0_0000_0000 | 64'(i);
      @(negedge clk);
    end
    readdatavalid = 1'b0;
    readdata = '0;
    @(negedge clk);
    check("stale_discarded", 64'(st_valid), 64'(0));
    repeat (20) @(negedge clk);
    vc = vecs[0];
    vc.base = 32'h0000_7000;
    run_frame(vc, -1, cyc_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
